// File: rtl/block_pkg.sv
// block_pkg: screen geometry, coordinate widths and drawer state encoding shared by the block drawer.
package block_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int W_W = 6;
  localparam int H_W = 5;
  localparam int C_W = 9;
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
endpackage

// File: rtl/rect_scanner.sv
// rect_scanner: row-major pixel walker over a W x H rectangle with registered pixel, plot (clip-aware) and colour.
module rect_scanner
  import block_pkg::*;
#(
  parameter logic [COLOUR_W-1:0] BORDER_COLOUR = 3'b111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic                stop,
  input  logic                border,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [W_W-1:0]      w,
  input  logic [H_W-1:0]      h,
  input  logic [COLOUR_W-1:0] fill,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                last
);
  logic [X_W-1:0] bx, n_bx;
  logic [W_W-1:0] rw, n_w, col, n_col;
  logic [H_W-1:0] rh, n_h, row, n_row;
  logic [C_W-1:0] cx, n_cx, cy, n_cy;
  logic [COLOUR_W-1:0] fill_r, n_fill;
  logic bord, n_bord, active, n_active, wrap, edge_px;
  assign wrap = col == rw - W_W'(1);
  assign last = wrap && row == rh - H_W'(1);
  assign x = cx[X_W-1:0];
  assign y = cy[Y_W-1:0];
  always_comb begin
    n_bx = bx;
    n_w = rw;
    n_h = rh;
    n_fill = fill_r;
    n_bord = bord;
    n_col = col;
    n_row = row;
    n_cx = cx;
    n_cy = cy;
    n_active = active;
    if (load) begin
      n_bx = x0;
      n_w = w;
      n_h = h;
      n_fill = fill;
      n_bord = border;
      n_col = '0;
      n_row = '0;
      n_cx = C_W'(x0);
      n_cy = C_W'(y0);
      n_active = 1'b1;
    end else if (step) begin
      n_col = wrap ? '0 : col + W_W'(1);
      n_row = wrap ? row + H_W'(1) : row;
      n_cx = wrap ? C_W'(bx) : cx + C_W'(1);
      n_cy = wrap ? cy + C_W'(1) : cy;
    end else if (stop) begin
      n_active = 1'b0;
    end
  end
  assign edge_px = n_col == '0 || n_col == n_w - W_W'(1) || n_row == '0 || n_row == n_h - H_W'(1);
  // 9-bit coordinates let off-screen pixels be recognised before truncation
  always_ff @(posedge clk) begin
    if (!reset) begin
      bx <= '0;
      rw <= '0;
      rh <= '0;
      fill_r <= '0;
      bord <= 1'b0;
      col <= '0;
      row <= '0;
      cx <= '0;
      cy <= '0;
      active <= 1'b0;
      plot <= 1'b0;
      colour <= '0;
    end else begin
      bx <= n_bx;
      rw <= n_w;
      rh <= n_h;
      fill_r <= n_fill;
      bord <= n_bord;
      col <= n_col;
      row <= n_row;
      cx <= n_cx;
      cy <= n_cy;
      active <= n_active;
      plot <= n_active && n_cx < C_W'(SCREEN_W) && n_cy < C_W'(SCREEN_H);
      colour <= n_active ? (n_bord && edge_px ? BORDER_COLOUR : n_fill) : '0;
    end
  end
endmodule

// File: rtl/block_drawer.sv
// block_drawer: erases the previous block rectangle then draws the new one, one pixel per clock.
// Define BLOCK_DRAWER_BORDER_EN to outline drawn blocks in BORDER_COLOUR.
module block_drawer
  import block_pkg::*;
#(
  parameter int                  HEIGHT        = 8,
  parameter int                  MAX_W         = 56,
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = 3'b000,
  parameter logic [COLOUR_W-1:0] BORDER_COLOUR = 3'b111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [W_W-1:0]      width_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  state_t state, next;
  logic [X_W-1:0] new_x, prev_x, src_x;
  logic [Y_W-1:0] new_y, prev_y, src_y;
  logic [W_W-1:0] new_w, prev_w, src_w, in_w;
  logic [COLOUR_W-1:0] new_c, fill;
  logic prev_valid, load, step, stop, border, last;
  assign in_w = width_in > W_W'(MAX_W) ? W_W'(MAX_W) : width_in;
  always_comb begin
    next = state;
    load = 1'b0;
    step = 1'b0;
    stop = 1'b0;
    src_x = new_x;
    src_y = new_y;
    src_w = new_w;
    fill = new_c;
    border = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (prev_valid && prev_w != '0) begin
          next = ERASE;
          load = 1'b1;
          src_x = prev_x;
          src_y = prev_y;
          src_w = prev_w;
          fill = BG_COLOUR;
        end else if (in_w != '0) begin
          next = DRAW;
          load = 1'b1;
          src_x = x_in;
          src_y = y_in;
          src_w = in_w;
          fill = colour_in;
        end else next = DONE;
      end
      ERASE: if (last) begin
        next = new_w != '0 ? DRAW : DONE;
        load = new_w != '0;
        stop = new_w == '0;
      end else step = 1'b1;
      DRAW: if (last) begin
        next = DONE;
        stop = 1'b1;
      end else step = 1'b1;
      default: next = IDLE;
    endcase
`ifdef BLOCK_DRAWER_BORDER_EN
    border = next == DRAW;
`else
    border = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      new_x <= '0;
      new_y <= '0;
      new_w <= '0;
      new_c <= '0;
      prev_x <= '0;
      prev_y <= '0;
      prev_w <= '0;
      prev_valid <= 1'b0;
    end else begin
      state <= next;
      busy <= next == ERASE || next == DRAW;
      done <= next == DONE;
      if (state == IDLE && start) begin
        new_x <= x_in;
        new_y <= y_in;
        new_w <= in_w;
        new_c <= colour_in;
      end
      if (state == DONE) begin
        prev_x <= new_x;
        prev_y <= new_y;
        prev_w <= new_w;
        prev_valid <= 1'b1;
      end
    end
  end
  rect_scanner #(.BORDER_COLOUR(BORDER_COLOUR)) scanner (
    .clk(clk),
    .reset(reset),
    .load(load),
    .step(step),
    .stop(stop),
    .border(border),
    .x0(src_x),
    .y0(src_y),
    .w(src_w),
    .h(H_W'(HEIGHT)),
    .fill(fill),
    .x(vga_x),
    .y(vga_y),
    .colour(vga_colour),
    .plot(vga_plot),
    .last(last)
  );
endmodule

// File: tb/tb_block_drawer.sv
// tb_block_drawer: scoreboard bench; expected plotted pixels are queued per pass and popped as the DUT plots them.
module tb_block_drawer;
  localparam int H = 8;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [5:0] width_in = '0;
  logic [2:0] colour_in = '0;
  logic busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} px_t;
  px_t q[$];
  px_t e;
  int checks = 0, failures = 0, plots = 0;
  int pv = 0, pxx = 0, pyy = 0, pw = 0;
  block_drawer dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .width_in(width_in), .colour_in(colour_in), .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic push_rect(input int x, input int y, input int w, input logic [2:0] c, input bit bord, output int n);
    n = 0;
    for (int r = 0; r < H; r++)
      for (int k = 0; k < w; k++)
        if (x + k < 160 && y + r < 120) begin
          q.push_back({8'(x + k), 7'(y + r), (bord && (r == 0 || r == H - 1 || k == 0 || k == w - 1)) ? 3'b111 : c});
          n++;
        end
  endtask
  always @(negedge clk)
    if (vga_plot) begin
      plots++;
      if (q.size() == 0) check("extra_plot", 1, 0);
      else begin
        e = q.pop_front();
        check("pix_x", vga_x, e.x);
        check("pix_y", vga_y, e.y);
        check("pix_colour", vga_colour, e.c);
      end
    end
  task automatic run_pass(input int x, input int y, input int w, input logic [2:0] c, input int ign_at, input int abort_at);
    int exp_plots, n, cyc, total;
    bit got_done, bord;
    exp_plots = 0;
    got_done = 0;
`ifdef BLOCK_DRAWER_BORDER_EN
    bord = 1;
`else
    bord = 0;
`endif
    total = ((pv != 0 && pw != 0) ? pw * H : 0) + w * H;
    if (pv != 0 && pw != 0) begin
      push_rect(pxx, pyy, pw, 3'b000, 0, n);
      exp_plots += n;
    end
    push_rect(x, y, w, c, bord, n);
    exp_plots += n;
    plots = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    x_in = 8'(x);
    y_in = 7'(y);
    width_in = 6'(w);
    colour_in = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in = 8'($urandom);
    y_in = 7'($urandom);
    width_in = 6'($urandom_range(0, 56));
    colour_in = 3'($urandom);
    for (cyc = 1; cyc <= total + 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && total > 0) check("busy_first", busy, 1);
      start = (cyc == ign_at);
      if (cyc == abort_at) begin
        reset = 1'b0;
        #1;
        q.delete();
        @(negedge clk);
        check("abort_plot", vga_plot, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_xy", {vga_x, vga_y, vga_colour}, 0);
        reset = 1'b1;
        pv = 0;
        pw = 0;
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        return;
      end
      if (done) begin
        got_done = 1;
        break;
      end
    end
    start = 1'b0;
    check("done_cycle", got_done ? cyc : -1, total + 1);
    check("busy_at_done", busy, 0);
    check("plot_count", plots, exp_plots);
    check("queue_empty", q.size(), 0);
    pv = 1;
    pxx = x;
    pyy = y;
    pw = w;
    repeat (3) begin
      @(negedge clk);
      check("no_extra_done", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_outputs", {vga_x, vga_y, vga_colour}, 0);
    reset = 1'b1;
    run_pass(10, 100, 4, 3'b100, 0, 0);
    run_pass(11, 100, 4, 3'b100, 40, 0);
    run_pass(158, 100, 4, 3'b010, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    pv = 0;
    pw = 0;
    run_pass(50, 50, 0, 3'b011, 0, 0);
    run_pass(20, 5, 3, 3'b101, 0, 10);
    run_pass(30, 20, 2, 3'b110, 0, 0);
    run_pass(0, 115, 3, 3'b001, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/block_drawer.md
# block_drawer

Rendering stage directly downstream of the block x-coordinate register. On each `start` it erases the previously drawn block rectangle (background colour) and draws the block at the new (x, y) position. It emits one pixel write per clock to the VGA adapter's plot interface, and pulses `done` when finished, so the game controller can advance the coordinate register only between frames.

## Interface
Parameters:
- `HEIGHT`, 8: block height in pixels (1..16)
- `MAX_W`, 56: maximum block width in pixels
- `BG_COLOUR`, 3'b000: colour used for erase
- `BORDER_COLOUR`, 3'b111: outline colour (only with border feature)

Ports:
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  reset, synchronous, active-low; clock clk
- `start`  in  1  request one erase+draw pass; sampled only in IDLE
- `x_in`  in  8  new left x (0..159), from coordinate register
- `y_in`  in  7  new top y (0..119)
- `width_in`  in  6  new block width (0..MAX_W)
- `colour_in`  in  3  block fill colour
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse after last pixel
- `vga_x`  out  8  pixel x
- `vga_y`  out  7  pixel y
- `vga_colour`  out  3  pixel colour
- `vga_plot`  out  1  write enable for current pixel

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- IDLE + `start`: latch x_in/y_in/width_in/colour_in as NEW; go to ERASE if `prev_valid` and PREV width ≠ 0, else DRAW.
- ERASE: scan PREV rectangle row-major (x fastest), colour BG_COLOUR; after last pixel -> DRAW.
- DRAW: scan NEW rectangle, colour `colour_in` (latched); after last pixel -> DONE.
- DONE: `done`=1 for one cycle; copy NEW into PREV, set `prev_valid`; -> IDLE.
- `start` outside IDLE ignored (not queued); inputs changing mid-pass have no effect.
- Width 0: pass contributes 0 cycles (ERASE skipped / DRAW skipped straight to DONE).
- Clipping: pixels with x > 159 or y > 119 still consume a cycle but `vga_plot`=0.
- Coordinate arithmetic 9-bit internally to detect overflow before clipping; outputs truncated to 8/7 bits.
- Reset: all outputs 0, state IDLE, `prev_valid`=0, PREV cleared. Reset mid-pass aborts immediately; no further plots, no `done`.

## Timing
- `start` sampled at edge 0; first pixel presented on outputs in cycle 1; one pixel per cycle, no gaps between ERASE and DRAW.
- Pass length: Wp·HEIGHT (erase) + Wn·HEIGHT (draw) pixel cycles; `done` in the cycle after the last pixel.
- `busy`=1 from cycle 1 through the last pixel cycle; `busy`=0 while `done`=1.
- All outputs registered; `vga_plot`=0 whenever not in ERASE/DRAW.
- Earliest next `start` accepted in the cycle after `done`.

## Configuration
- `BLOCK_DRAWER_BORDER_EN` defined: in DRAW, pixels on the rectangle's first/last row or first/last column use BORDER_COLOUR, interior uses `colour_in`; cycle counts unchanged.
- Undefined: whole rectangle in `colour_in`; BORDER_COLOUR unused.

## Structure
- Shared package `block_pkg`: SCREEN_W=160, SCREEN_H=120, COLOUR_W=3, state enum (IDLE/ERASE/DRAW/DONE), coordinate widths.
- Sub-module `rect_scanner`: row/column counters over a W×H rectangle with load, step, last-pixel flag, and clip flag. One instance, reloaded per pass.

## Test plan
- After reset, start x=10,y=100,w=4,colour=3'b100 -> 32 plots (10,100)…(13,107) in cycles 1–32, no erase, `done` in cycle 33.
- Then start x=11 same y/w -> 32 erase plots colour 000 at (10..13,100..107), then 32 draws at (11..14), `done` in cycle 65.
- `start` pulsed during DRAW -> ignored; no extra pass; totals unchanged.
- x=158,w=4 -> 32 cycles, `vga_plot` high only for x=158,159 (16 plots).
- w=0 first pass -> `done` in cycle 1, no plots; reset asserted mid-DRAW -> outputs 0 next cycle, no `done`, next pass performs no erase.
- With BLOCK_DRAWER_BORDER_EN, w=4 -> 20 border pixels colour 111, 12 interior colour `colour_in`.
